// File: rtl/vpd_cap_initiator_pkg.sv
// Shared types and constants for the VPD capability initiator.
// The optional request timeout is enabled by defining VPD_TIMEOUT_EN.
package vpd_cap_pkg;

  localparam int unsigned VPD_F_BIT  = 15;
  localparam int unsigned VPD_ADDR_W = 15;
  localparam int unsigned VPD_DATA_W = 32;
  localparam logic [VPD_DATA_W-1:0] VPD_TIMEOUT_DATA = 32'hFFFF_FFFF;

  // Bit positions inside vpd_err_sticky
  localparam int unsigned ERR_UNIMPL  = 0;
  localparam int unsigned ERR_PROTO   = 1;
  localparam int unsigned ERR_TIMEOUT = 2;
  localparam int unsigned ERR_W       = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } vpd_state_e;

endpackage

// File: rtl/vpd_cap_initiator_if.sv
// cfg_vpd_* request/completion handshake between the capability initiator
// (master) and the flash/VPD responder (slave).
interface vpd_cap_initiator_if;
  import vpd_cap_pkg::*;

  logic [VPD_ADDR_W-1:0] cfg_vpd_addr;
  logic                  cfg_vpd_wren;
  logic [VPD_DATA_W-1:0] cfg_vpd_wdata;
  logic                  cfg_vpd_rden;
  logic [VPD_DATA_W-1:0] vpd_cfg_rdata;
  logic                  vpd_cfg_done;
  logic                  vpd_err_unimplemented_addr;

  modport master (
    output cfg_vpd_addr, cfg_vpd_wren, cfg_vpd_wdata, cfg_vpd_rden,
    input  vpd_cfg_rdata, vpd_cfg_done, vpd_err_unimplemented_addr
  );

  modport slave (
    input  cfg_vpd_addr, cfg_vpd_wren, cfg_vpd_wdata, cfg_vpd_rden,
    output vpd_cfg_rdata, vpd_cfg_done, vpd_err_unimplemented_addr
  );

endinterface

// File: rtl/vpd_cap_initiator.sv
// VPD capability register front end: Address/Data registers, held request
// sequencing, completion capture and sticky errors. Optional: VPD_TIMEOUT_EN.
module vpd_cap_initiator
  import vpd_cap_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clock_afu,
  input  logic        reset_afu_n,
  input  logic        cap_addr_wr,
  input  logic [15:0] cap_addr_wdata,
  input  logic        cap_data_wr,
  input  logic [31:0] cap_data_wdata,
  output logic [15:0] cap_addr_rdata,
  output logic [31:0] cap_data_rdata,
  vpd_cap_initiator_if.master vpd,
  output logic        vpd_busy,
  output logic [2:0]  vpd_err_sticky,
  input  logic        vpd_err_clr
);

  vpd_state_e            state;
  logic                  f_q;
  logic [VPD_ADDR_W-1:0] addr_q;
  logic [VPD_DATA_W-1:0] data_q;
  logic [ERR_W-1:0]      err_q;
  logic [ERR_W-1:0]      err_set;
  logic                  busy;
  logic                  finish;
  logic                  timed_out;

  assign busy = (state != IDLE);

`ifdef VPD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Held at zero while idle, so every request starts counting from zero.
  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      tmo_cnt <= '0;
    end else if (!busy) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A real completion on the last allowed cycle takes precedence.
  assign timed_out = busy && !vpd.vpd_cfg_done &&
                     (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0) && (TIMEOUT_W != 0);
  assign timed_out      = 1'b0;
`endif

  assign finish = busy && (vpd.vpd_cfg_done || timed_out);

  always_comb begin
    err_set              = '0;
    err_set[ERR_UNIMPL]  = busy && vpd.vpd_cfg_done && vpd.vpd_err_unimplemented_addr;
    // Register writes while a request is held and completions with nothing
    // outstanding are both protocol errors.
    err_set[ERR_PROTO]   = (busy && (cap_addr_wr || cap_data_wr)) ||
                           (!busy && vpd.vpd_cfg_done);
    err_set[ERR_TIMEOUT] = timed_out;
  end

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      state  <= IDLE;
      f_q    <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= '0;
    end else begin
      err_q <= (err_q & ~{ERR_W{vpd_err_clr}}) | err_set;
      case (state)
        IDLE: begin
          if (cap_data_wr) begin
            data_q <= cap_data_wdata;
          end
          if (cap_addr_wr) begin
            f_q    <= cap_addr_wdata[VPD_F_BIT];
            addr_q <= cap_addr_wdata[VPD_ADDR_W-1:0];
            state  <= cap_addr_wdata[VPD_F_BIT] ? WR_WAIT : RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (finish) begin
            f_q   <= 1'b0;
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (finish) begin
            f_q    <= 1'b1;
            data_q <= timed_out ? VPD_TIMEOUT_DATA : vpd.vpd_cfg_rdata;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vpd.cfg_vpd_addr  = addr_q;
  assign vpd.cfg_vpd_wren  = (state == WR_WAIT);
  assign vpd.cfg_vpd_rden  = (state == RD_WAIT);
  assign vpd.cfg_vpd_wdata = data_q;

  assign cap_addr_rdata = {f_q, addr_q};
  assign cap_data_rdata = data_q;
  assign vpd_busy       = busy;
  assign vpd_err_sticky = err_q;

endmodule

// File: tb/tb_vpd_cap_initiator.sv
// Self-checking bench for vpd_cap_initiator: directed vector table, corner
// sequences and randomized transactions against a register-level model.
module tb_vpd_cap_initiator;
  import vpd_cap_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clock_afu = 1'b0;
  logic        reset_afu_n = 1'b1;
  logic        cap_addr_wr = 1'b0;
  logic [15:0] cap_addr_wdata = '0;
  logic        cap_data_wr = 1'b0;
  logic [31:0] cap_data_wdata = '0;
  logic [15:0] cap_addr_rdata;
  logic [31:0] cap_data_rdata;
  logic        vpd_busy;
  logic [2:0]  vpd_err_sticky;
  logic        vpd_err_clr = 1'b0;

  vpd_cap_initiator_if vif ();

  vpd_cap_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock_afu      (clock_afu),
    .reset_afu_n    (reset_afu_n),
    .cap_addr_wr    (cap_addr_wr),
    .cap_addr_wdata (cap_addr_wdata),
    .cap_data_wr    (cap_data_wr),
    .cap_data_wdata (cap_data_wdata),
    .cap_addr_rdata (cap_addr_rdata),
    .cap_data_rdata (cap_data_rdata),
    .vpd            (vif),
    .vpd_busy       (vpd_busy),
    .vpd_err_sticky (vpd_err_sticky),
    .vpd_err_clr    (vpd_err_clr)
  );

  always #5 clock_afu = ~clock_afu;

  int checks = 0;
  int errors = 0;

  // Reference register image: {F, addr}, Data, sticky errors
  logic [15:0] m_areg = '0;
  logic [31:0] m_dreg = '0;
  logic [2:0]  m_err  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_afu);
    #1;
  endtask

  // Handshake monitors: exclusivity, stability, idle gap between requests
  int   both_viol = 0;
  int   stab_viol = 0;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [31:0] prev_wd = '0;

  always @(negedge clock_afu) begin
    if (vif.cfg_vpd_wren && vif.cfg_vpd_rden) both_viol++;
    if ((prev_wr && vif.cfg_vpd_rden) || (prev_rd && vif.cfg_vpd_wren)) stab_viol++;
    if ((prev_wr && vif.cfg_vpd_wren) || (prev_rd && vif.cfg_vpd_rden)) begin
      if (vif.cfg_vpd_addr !== prev_addr ||
          (vif.cfg_vpd_wren && vif.cfg_vpd_wdata !== prev_wd)) stab_viol++;
    end
    prev_wr   = vif.cfg_vpd_wren;
    prev_rd   = vif.cfg_vpd_rden;
    prev_addr = vif.cfg_vpd_addr;
    prev_wd   = vif.cfg_vpd_wdata;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic pulse_data(input logic [31:0] d);
    cap_data_wr    = 1'b1;
    cap_data_wdata = d;
    tick();
    cap_data_wr = 1'b0;
    m_dreg      = d;
  endtask

  task automatic start_req(input logic is_wr, input logic [14:0] a, input string tag);
    cap_addr_wr    = 1'b1;
    cap_addr_wdata = {is_wr, a};
    tick();
    cap_addr_wr = 1'b0;
    m_areg      = {is_wr, a};
    chk({tag, "_req_lines"}, 32'({vif.cfg_vpd_wren, vif.cfg_vpd_rden, vpd_busy}),
        32'({is_wr, ~is_wr, 1'b1}));
    chk({tag, "_req_addr"}, 32'(vif.cfg_vpd_addr), 32'(a));
    if (is_wr) chk({tag, "_req_wdata"}, vif.cfg_vpd_wdata, m_dreg);
  endtask

  task automatic finish_req(input logic is_wr, input logic [31:0] rd, input logic unimpl);
    vif.vpd_cfg_done               = 1'b1;
    vif.vpd_cfg_rdata              = rd;
    vif.vpd_err_unimplemented_addr = unimpl;
    tick();
    vif.vpd_cfg_done               = 1'b0;
    vif.vpd_err_unimplemented_addr = 1'b0;
    vif.vpd_cfg_rdata              = $urandom;
    if (is_wr) begin
      m_areg[15] = 1'b0;
    end else begin
      m_areg[15] = 1'b1;
      m_dreg     = rd;
    end
    if (unimpl) m_err[ERR_UNIMPL] = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_addr_reg"}, 32'(cap_addr_rdata), 32'(m_areg));
    chk({tag, "_data_reg"}, cap_data_rdata, m_dreg);
    chk({tag, "_err"}, 32'(vpd_err_sticky), 32'(m_err));
    chk({tag, "_idle_lines"}, 32'({vif.cfg_vpd_wren, vif.cfg_vpd_rden, vpd_busy}), 32'd0);
  endtask

  task automatic clear_err(input string tag);
    vpd_err_clr = 1'b1;
    tick();
    vpd_err_clr = 1'b0;
    m_err       = '0;
    chk({tag, "_err_clr"}, 32'(vpd_err_sticky), 32'd0);
  endtask

  typedef struct {
    logic        is_wr;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned delay;
    logic        unimpl;
    logic [15:0] exp_areg;
    logic [31:0] exp_dreg;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b1, 15'h0010, 32'hDEAD_BEEF, 32'h0000_0000, 5, 1'b0, 16'h0010, 32'hDEAD_BEEF, 3'b000};
    vecs[1] = '{1'b0, 15'h0024, 32'h0000_0000, 32'h1234_5678, 3, 1'b0, 16'h8024, 32'h1234_5678, 3'b000};
    vecs[2] = '{1'b0, 15'h7FFF, 32'h0000_0000, 32'hA55A_0FF0, 2, 1'b1, 16'hFFFF, 32'hA55A_0FF0, 3'b001};
    vecs[3] = '{1'b1, 15'h0003, 32'h0BAD_CAFE, 32'h0000_0000, 0, 1'b0, 16'h0003, 32'h0BAD_CAFE, 3'b001};

    vif.vpd_cfg_rdata              = '0;
    vif.vpd_cfg_done               = 1'b0;
    vif.vpd_err_unimplemented_addr = 1'b0;

    // Reset state
    #1 reset_afu_n = 1'b0;
    #2;
    chk("rst_addr_reg", 32'(cap_addr_rdata), 32'd0);
    chk("rst_data_reg", cap_data_rdata, 32'd0);
    chk("rst_err", 32'(vpd_err_sticky), 32'd0);
    chk("rst_lines", 32'({vif.cfg_vpd_wren, vif.cfg_vpd_rden, vpd_busy}), 32'd0);
    chk("rst_cfg_addr", 32'(vif.cfg_vpd_addr), 32'd0);
    chk("rst_cfg_wdata", vif.cfg_vpd_wdata, 32'd0);
    repeat (2) @(posedge clock_afu);
    @(negedge clock_afu) reset_afu_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 4; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].is_wr) pulse_data(vecs[i].wdata);
      start_req(vecs[i].is_wr, vecs[i].addr, tag);
      repeat (vecs[i].delay) tick();
      finish_req(vecs[i].is_wr, vecs[i].rdata, vecs[i].unimpl);
      chk({tag, "_addr_reg"}, 32'(cap_addr_rdata), 32'(vecs[i].exp_areg));
      chk({tag, "_data_reg"}, cap_data_rdata, vecs[i].exp_dreg);
      chk({tag, "_err"}, 32'(vpd_err_sticky), 32'(vecs[i].exp_err));
      chk({tag, "_idle_lines"}, 32'({vif.cfg_vpd_wren, vif.cfg_vpd_rden, vpd_busy}), 32'd0);
    end
    clear_err("vec");

    // Register writes during RD_WAIT are ignored and flagged
    start_req(1'b0, 15'h0024, "busy");
    tick();
    cap_addr_wr    = 1'b1;
    cap_addr_wdata = 16'h8000;
    cap_data_wr    = 1'b1;
    cap_data_wdata = 32'h0000_0001;
    tick();
    cap_addr_wr = 1'b0;
    cap_data_wr = 1'b0;
    m_err[ERR_PROTO] = 1'b1;
    chk("busy_addr_kept", 32'(cap_addr_rdata), 32'h0000_0024);
    chk("busy_data_kept", cap_data_rdata, m_dreg);
    chk("busy_err", 32'(vpd_err_sticky), 32'b010);
    chk("busy_rden_held", 32'({vif.cfg_vpd_rden, vif.cfg_vpd_addr}), 32'h0000_8024);
    finish_req(1'b0, 32'h1111_2222, 1'b0);
    check_regs("busy_done");
    clear_err("busy");

    // Spurious done while idle together with clear: set wins
    vpd_err_clr      = 1'b1;
    vif.vpd_cfg_done = 1'b1;
    tick();
    vpd_err_clr      = 1'b0;
    vif.vpd_cfg_done = 1'b0;
    m_err            = 3'b010;
    check_regs("clr_vs_set");
    clear_err("clr_vs_set");

    // Done and an address write in the same cycle
    pulse_data(32'h5555_AAAA);
    start_req(1'b1, 15'h0100, "simul");
    tick();
    cap_addr_wr      = 1'b1;
    cap_addr_wdata   = 16'h0200;
    finish_req(1'b1, 32'h0, 1'b0);
    cap_addr_wr      = 1'b0;
    m_err[ERR_PROTO] = 1'b1;
    check_regs("simul");
    tick();
    chk("simul_no_new_req", 32'({vif.cfg_vpd_wren, vif.cfg_vpd_rden, vpd_busy}), 32'd0);
    clear_err("simul");

`ifdef VPD_TIMEOUT_EN
    // Read with no done: forced completion after TMO cycles
    start_req(1'b0, 15'h0077, "tmo");
    repeat (TMO - 1) tick();
    chk("tmo_rden_last", 32'(vif.cfg_vpd_rden), 32'd1);
    tick();
    m_areg = 16'h8077;
    m_dreg = 32'hFFFF_FFFF;
    m_err  = 3'b100;
    check_regs("tmo");
    vif.vpd_cfg_done = 1'b1;
    tick();
    vif.vpd_cfg_done = 1'b0;
    m_err[ERR_PROTO] = 1'b1;
    chk("tmo_late_done", 32'(vpd_err_sticky), 32'b110);
    clear_err("tmo");
`endif

    // Asynchronous reset in the middle of WR_WAIT
    pulse_data(32'hCAFE_F00D);
    start_req(1'b1, 15'h0042, "arst");
    cap_data_wr = 1'b1;
    tick();
    cap_data_wr = 1'b0;
    chk("arst_pre_err", 32'(vpd_err_sticky), 32'b010);
    #2 reset_afu_n = 1'b0;
    #1;
    m_areg = '0;
    m_dreg = '0;
    m_err  = '0;
    check_regs("arst");
    repeat (2) @(posedge clock_afu);
    @(negedge clock_afu) reset_afu_n = 1'b1;
    start_req(1'b0, 15'h0055, "arst_rd");
    repeat (3) tick();
    finish_req(1'b0, 32'h0F0F_0F0F, 1'b0);
    check_regs("arst_rd");

    // Randomized transactions with protocol abuse
    for (int n = 0; n < 40; n++) begin
      logic        is_wr;
      logic [14:0] a;
      int unsigned dly;
      string       tag;
      tag   = $sformatf("rnd%0d", n);
      is_wr = 1'($urandom_range(0, 1));
      a     = 15'($urandom);
      if ($urandom_range(0, 1) == 1) pulse_data($urandom);
      start_req(is_wr, a, tag);
      dly = $urandom_range(0, 10);
      for (int d = 0; d < int'(dly); d++) begin
        if ($urandom_range(0, 7) == 0) begin
          cap_addr_wr    = 1'($urandom_range(0, 1));
          cap_data_wr    = ~cap_addr_wr;
          cap_addr_wdata = 16'($urandom);
          cap_data_wdata = $urandom;
          m_err[ERR_PROTO] = 1'b1;
        end
        tick();
        cap_addr_wr = 1'b0;
        cap_data_wr = 1'b0;
      end
      finish_req(is_wr, $urandom, ($urandom_range(0, 5) == 0));
      check_regs(tag);
      case ($urandom_range(0, 5))
        0: begin
          vif.vpd_cfg_done = 1'b1;
          tick();
          vif.vpd_cfg_done = 1'b0;
          m_err[ERR_PROTO] = 1'b1;
          chk({tag, "_spurious"}, 32'(vpd_err_sticky), 32'(m_err));
        end
        1: clear_err(tag);
        default: tick();
      endcase
    end

    chk("no_wren_rden_overlap", 32'(both_viol), 32'd0);
    chk("req_stable", 32'(stab_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
